// File: rtl/ones_count_pkg.sv
// Shared types and elaboration helpers for the ones-count sequencer.
package ones_count_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int n_groups(input int width);
        return (width + 2) / 3;
    endfunction

    function automatic int to_count_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Counter width that stays at least one bit for single-value ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/oc_group_mux.sv
// Selects the current 3-bit group of the shadow word for the external cell,
// zero-padding past the top bit and forcing 0 when not driving.
module oc_group_mux
    import ones_count_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int IW    = 2
) (
    input  logic [WIDTH-1:0] i_word,
    input  logic [IW-1:0]    i_idx,
    input  logic             i_en,
    output logic             o_a,
    output logic             o_b,
    output logic             o_c
);

    localparam int G  = n_groups(WIDTH);
    localparam int PW = 3 * G;

    logic [PW-1:0] w_pad;
    logic [2:0]    w_grp;

    assign w_pad = PW'(i_word);

    always_comb begin
        w_grp = '0;
        for (int k = 0; k < G; k++) begin
            if (i_idx == IW'(k)) begin
                w_grp = w_pad[3*k +: 3];
            end
        end
    end

    assign o_a = i_en & w_grp[0];
    assign o_b = i_en & w_grp[1];
    assign o_c = i_en & w_grp[2];

endmodule

// File: rtl/ones_count_sequencer.sv
// Population count of a WIDTH-bit word, three bits at a time, through one
// external full-adder style ones-counter cell with a programmable settle time.
module ones_count_sequencer
    import ones_count_pkg::*;
#(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 2,
    parameter int CW     = to_count_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    count,
    output logic             oc_a,
    output logic             oc_b,
    output logic             oc_c,
    input  logic             oc_y0,
    input  logic             oc_y1
);

    localparam int G  = n_groups(WIDTH);
    localparam int IW = idx_width(G);
    localparam int SW = idx_width(SETTLE);

    localparam logic [IW-1:0] LAST_IDX    = IW'(G - 1);
    localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_shadow;
    logic [CW-1:0]    r_acc;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_sum;
    logic [IW-1:0]    r_idx;
    logic [SW-1:0]    r_settle;
    logic             w_drv_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = DRIVE;
            DRIVE:   if (r_settle == LAST_SETTLE) w_next = SAMPLE;
            SAMPLE:  w_next = (r_idx == LAST_IDX) ? DONE : DRIVE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        ready    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        w_drv_en = 1'b0;
        case (r_state)
            IDLE:    ready = 1'b1;
            DRIVE,
            SAMPLE: begin
                busy     = 1'b1;
                w_drv_en = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Cell output is trusted as-is; the accumulator cannot exceed WIDTH.
    assign w_sum = r_acc + CW'({oc_y1, oc_y0});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_idx    <= '0;
            r_settle <= '0;
            r_count  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_idx    <= '0;
                        r_settle <= '0;
                    end
                end
                DRIVE: begin
                    r_settle <= r_settle + 1'b1;
                end
                SAMPLE: begin
                    r_acc <= w_sum;
                    if (r_idx == LAST_IDX) begin
                        r_count <= w_sum;
                    end else begin
                        r_idx    <= r_idx + 1'b1;
                        r_settle <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Shadow copy isolates the operation from later data_in changes.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            r_shadow <= data_in;
        end
    end

    assign count = r_count;

    oc_group_mux #(
        .WIDTH (WIDTH),
        .IW    (IW)
    ) u_mux (
        .i_word (r_shadow),
        .i_idx  (r_idx),
        .i_en   (w_drv_en),
        .o_a    (oc_a),
        .o_b    (oc_b),
        .o_c    (oc_c)
    );

endmodule

// File: tb/tb_ones_count_sequencer.sv
// Directed bench: two sequencers (12-bit/SETTLE=2 and 8-bit/SETTLE=1), each
// paired with a delayed behavioural model of the ones-counter cell.
module tb_ones_count_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] data_in;
    logic        ready, busy, done;
    logic [3:0]  count;
    logic        oc_a, oc_b, oc_c;
    logic [1:0]  y;

    logic        start2;
    logic [7:0]  data2;
    logic        ready2, busy2, done2;
    logic [3:0]  count2;
    logic        oc_a2, oc_b2, oc_c2;
    logic [1:0]  y2;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          edges;
    logic [2:0]  trace [0:63];
    logic        seen_done;

    always #5 clk = ~clk;

    ones_count_sequencer #(.WIDTH(12), .SETTLE(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .ready(ready), .busy(busy), .done(done), .count(count),
        .oc_a(oc_a), .oc_b(oc_b), .oc_c(oc_c), .oc_y0(y[0]), .oc_y1(y[1])
    );

    ones_count_sequencer #(.WIDTH(8), .SETTLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start2), .data_in(data2),
        .ready(ready2), .busy(busy2), .done(done2), .count(count2),
        .oc_a(oc_a2), .oc_b(oc_b2), .oc_c(oc_c2), .oc_y0(y2[0]), .oc_y1(y2[1])
    );

    // Cell model: 7 ns propagation delay, sum of the three inputs.
    always @(oc_a or oc_b or oc_c)
        y <= #7 2'({1'b0, oc_a} + {1'b0, oc_b} + {1'b0, oc_c});
    always @(oc_a2 or oc_b2 or oc_c2)
        y2 <= #7 2'({1'b0, oc_a2} + {1'b0, oc_b2} + {1'b0, oc_c2});

    // Launches one word on the 12-bit DUT; edges = edge number of done, -1 on timeout.
    task automatic run_word(input logic [11:0] d);
        @(negedge clk);
        data_in = d;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = -1;
        for (int e = 0; e < 60; e++) begin
            if (e > 0) @(posedge clk);
            @(negedge clk);
            trace[e] = {oc_a, oc_b, oc_c};
            if (done) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; data_in = '0; start2 = 1'b0; data2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_chk++; if ({oc_a, oc_b, oc_c} !== 3'b000) begin n_fail++; $display("FAIL reset_oc: got %b want 000", {oc_a, oc_b, oc_c}); end
        n_chk++; if ({ready2, busy2, done2, count2} !== 7'b1000000) begin n_fail++; $display("FAIL reset_dut8: got %b want 1000000", {ready2, busy2, done2, count2}); end
        rst_n = 1'b1;
    endtask

    task automatic test_zero();
        run_word(12'h000);
        n_chk++; if (edges !== 12) begin n_fail++; $display("FAIL zero_latency: got %0d want 12", edges); end
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL zero_count: got %0d want 0", count); end
        @(negedge clk);
        n_chk++; if ({done, ready} !== 2'b01) begin n_fail++; $display("FAIL zero_done_pulse: got done,ready=%b want 01", {done, ready}); end
        n_chk++; if ({oc_a, oc_b, oc_c} !== 3'b000) begin n_fail++; $display("FAIL zero_idle_oc: got %b want 000", {oc_a, oc_b, oc_c}); end
    endtask

    task automatic test_all_ones();
        run_word(12'hFFF);
        n_chk++; if (edges !== 12) begin n_fail++; $display("FAIL ones_latency: got %0d want 12", edges); end
        n_chk++; if (count !== 4'd12) begin n_fail++; $display("FAIL ones_count: got %0d want 12", count); end
        n_chk++; if (trace[11] !== 3'b111) begin n_fail++; $display("FAIL ones_last_group: got %b want 111", trace[11]); end
    endtask

    task automatic test_pattern();
        // 12'hA5A groups {a,b,c}: 010, 110, 100, 101
        run_word(12'hA5A);
        n_chk++; if (count !== 4'd6) begin n_fail++; $display("FAIL a5a_count: got %0d want 6", count); end
        n_chk++; if (edges !== 12) begin n_fail++; $display("FAIL a5a_latency: got %0d want 12", edges); end
        n_chk++; if (trace[0] !== 3'b010 || trace[2] !== 3'b010) begin n_fail++; $display("FAIL a5a_g0: got %b/%b want 010", trace[0], trace[2]); end
        n_chk++; if (trace[3] !== 3'b110) begin n_fail++; $display("FAIL a5a_g1: got %b want 110", trace[3]); end
        n_chk++; if (trace[6] !== 3'b100) begin n_fail++; $display("FAIL a5a_g2: got %b want 100", trace[6]); end
        n_chk++; if (trace[9] !== 3'b101) begin n_fail++; $display("FAIL a5a_g3: got %b want 101", trace[9]); end
        n_chk++; if (trace[12] !== 3'b000) begin n_fail++; $display("FAIL a5a_done_oc: got %b want 000", trace[12]); end
    endtask

    task automatic test_width8();
        @(negedge clk);
        data2  = 8'hFF;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        edges = -1;
        for (int e = 0; e < 40; e++) begin
            if (e > 0) @(posedge clk);
            @(negedge clk);
            trace[e] = {oc_a2, oc_b2, oc_c2};
            if (done2) begin
                edges = e;
                break;
            end
        end
        n_chk++; if (edges !== 6) begin n_fail++; $display("FAIL w8_latency: got %0d want 6", edges); end
        n_chk++; if (count2 !== 4'd8) begin n_fail++; $display("FAIL w8_count: got %0d want 8", count2); end
        n_chk++; if (trace[0] !== 3'b111 || trace[2] !== 3'b111) begin n_fail++; $display("FAIL w8_full_groups: got %b/%b want 111", trace[0], trace[2]); end
        n_chk++; if (trace[4] !== 3'b110 || trace[5] !== 3'b110) begin n_fail++; $display("FAIL w8_padded_group: got %b/%b want 110", trace[4], trace[5]); end
    endtask

    task automatic test_ignore_and_back_to_back();
        @(negedge clk);
        data_in = 12'h007;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 data_in = 12'hFFF;
        start = 1'b1;
        @(negedge clk);
        n_chk++; if (count !== 4'd6) begin n_fail++; $display("FAIL held_count: got %0d want 6", count); end
        @(posedge clk);
        #1 start = 1'b0;
        edges = -1;
        for (int e = 2; e < 60; e++) begin
            if (e > 2) @(posedge clk);
            @(negedge clk);
            if (done) begin
                edges = e;
                break;
            end
        end
        n_chk++; if (edges !== 12) begin n_fail++; $display("FAIL ignore_latency: got %0d want 12", edges); end
        n_chk++; if (count !== 4'd3) begin n_fail++; $display("FAIL ignore_count: got %0d want 3", count); end
        // start raised in the IDLE cycle directly after DONE
        run_word(12'h0F0);
        n_chk++; if (edges !== 12) begin n_fail++; $display("FAIL b2b_latency: got %0d want 12", edges); end
        n_chk++; if (count !== 4'd4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", count); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        data_in = 12'hFFF;
        start   = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_chk++; if ({ready, busy, done} !== 3'b100) begin n_fail++; $display("FAIL mid_rst_state: got %b want 100", {ready, busy, done}); end
        n_chk++; if (count !== 4'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", count); end
        n_chk++; if ({oc_a, oc_b, oc_c} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_oc: got %b want 000", {oc_a, oc_b, oc_c}); end
        seen_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        n_chk++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_no_done: got %b want 0", seen_done); end
        run_word(12'h111);
        n_chk++; if (edges !== 12) begin n_fail++; $display("FAIL after_rst_latency: got %0d want 12", edges); end
        n_chk++; if (count !== 4'd3) begin n_fail++; $display("FAIL after_rst_count: got %0d want 3", count); end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_all_ones();
        test_pattern();
        test_width8();
        test_ignore_and_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
